// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Purpose:
//   WIDTH-bit universal register bank with complementary outputs. Each rising
//   Clk edge applies, in priority order: synchronous clear, synchronous set,
//   then one of eight Mode operations (hold, shift, rotate, load, invert).
//   Asynchronous Rst forces the bank to RST_VAL immediately.
//
// Parameters:
//   WIDTH    register width in bits, 2..64
//   RST_VAL  value forced into Q while Rst is high
//
// Ports:
//   Clk      in   clock, all state changes on the rising edge
//   Rst      in   asynchronous reset, active-high
//   Clr      in   synchronous clear (wins over Set)
//   Set      in   synchronous set, all bits to 1
//   Mode     in   [2:0] operation select
//   D        in   [WIDTH-1:0] parallel load data
//   SerR     in   serial input for shift-right, enters at the MSB
//   SerL     in   serial input for shift-left, enters at the LSB
//   Q        out  [WIDTH-1:0] register contents
//   Q_N      out  [WIDTH-1:0] complement of Q, held in its own register
//   SerOutR  out  Q[0], the bit a right shift discards next
//   SerOutL  out  Q[WIDTH-1], the bit a left shift discards next
//   Zero     out  1 when Q is all zeros
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             Set,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerR,
    input  logic             SerL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N,
    output logic             SerOutR,
    output logic             SerOutL,
    output logic             Zero
);

    // Mode encodings
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_INV  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    logic [WIDTH-1:0] q_next;

    // Next-state selection. Clr is checked before Set so that both together
    // clear the bank. The reserved encoding is deliberately identical to hold.
    always_comb begin
        q_next = Q;
        if (Clr) begin
            q_next = '0;
        end else if (Set) begin
            q_next = '1;
        end else begin
            case (Mode)
                MODE_HOLD: q_next = Q;
                MODE_SHR:  q_next = {SerR, Q[WIDTH-1:1]};
                MODE_SHL:  q_next = {Q[WIDTH-2:0], SerL};
                MODE_LOAD: q_next = D;
                MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
                MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_INV:  q_next = ~Q;
                MODE_RSVD: q_next = Q;
                default:   q_next = Q;
            endcase
        end
    end

    // Q and Q_N are separate registers loaded from the same next value, so
    // Q_N never lags Q and stays complementary through reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q   <= RST_VAL;
            Q_N <= ~RST_VAL;
        end else begin
            Q   <= q_next;
            Q_N <= ~q_next;
        end
    end

    // Status taps come straight off Q with no extra register stage.
    assign SerOutR = Q[0];
    assign SerOutL = Q[WIDTH-1];
    assign Zero    = (Q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=0). A behavioural model
// of the register contents is advanced from the operation rules using plain
// arithmetic; a compare process checks every DUT output against it on each
// falling clock edge. Hand-computed literals pin the model at key points.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int         W       = 8;
    localparam logic [7:0] RST_V   = 8'h00;
    localparam int         MSB_VAL = 1 << (W - 1);
    localparam int         MASK    = (1 << W) - 1;

    // ---------------------------------------------------------------- clock/reset
    logic         Clk;
    logic         Rst;
    logic         Clr;
    logic         Set;
    logic [2:0]   Mode;
    logic [W-1:0] D;
    logic         SerR;
    logic         SerL;
    logic [W-1:0] Q;
    logic [W-1:0] Q_N;
    logic         SerOutR;
    logic         SerOutL;
    logic         Zero;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    univ_shift_reg #(
        .WIDTH   (W),
        .RST_VAL (RST_V)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Clr     (Clr),
        .Set     (Set),
        .Mode    (Mode),
        .D       (D),
        .SerR    (SerR),
        .SerL    (SerL),
        .Q       (Q),
        .Q_N     (Q_N),
        .SerOutR (SerOutR),
        .SerOutL (SerOutL),
        .Zero    (Zero)
    );

    // ---------------------------------------------------------------- scoreboard
    int checks   = 0;
    int failures = 0;
    int m_q;            // model of the register contents as an integer
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Next contents computed from the operation rules with integer arithmetic.
    function automatic int model_next(input int q, input logic [2:0] mode, input int d,
                                      input logic serr, input logic serl,
                                      input logic clr, input logic set);
        int n;
        if (clr) return 0;
        if (set) return MASK;
        case (mode)
            3'd1:    n = (q / 2) + (serr ? MSB_VAL : 0);
            3'd2:    n = ((q * 2) % (MASK + 1)) + (serl ? 1 : 0);
            3'd3:    n = d;
            3'd4:    n = (q / 2) + ((q % 2) * MSB_VAL);
            3'd5:    n = ((q * 2) % (MASK + 1)) + ((q >= MSB_VAL) ? 1 : 0);
            3'd6:    n = MASK - q;
            default: n = q;
        endcase
        return n;
    endfunction

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("cyc_q",     Q,       m_q[W-1:0]);
            chk("cyc_qn",    Q_N,     (MASK - m_q) & MASK);
            chk("cyc_seroutr", SerOutR, m_q % 2);
            chk("cyc_seroutl", SerOutL, (m_q >= MSB_VAL) ? 1 : 0);
            chk("cyc_zero",  Zero,    (m_q == 0) ? 1 : 0);
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // Called at posedge+2; drives inputs, waits for the edge, advances the model,
    // and returns at the following posedge+2.
    task automatic step(input logic [2:0] mode, input logic [7:0] d,
                        input logic serr, input logic serl,
                        input logic clr, input logic set);
        Mode = mode;
        D    = d;
        SerR = serr;
        SerL = serl;
        Clr  = clr;
        Set  = set;
        @(posedge Clk);
        if (!Rst) m_q = model_next(m_q, mode, int'(d), serr, serl, clr, set);
        #2;
    endtask

    task automatic assert_rst;
        Rst = 1'b1;
        m_q = int'(RST_V);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        Rst  = 1'b0;
        Clr  = 1'b0;
        Set  = 1'b0;
        Mode = 3'd0;
        D    = '0;
        SerR = 1'b0;
        SerL = 1'b0;
        #0;
        assert_rst();
        #1;
        cmp_en = 1'b1;
        chk("por_q", Q, 8'h00);
        chk("por_qn", Q_N, 8'hFF);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Rst = 1'b0;

        // 1: reset asserted between edges
        step(3'd3, 8'h3C, 0, 0, 0, 0);
        chk("pre_rst_q", Q, 8'h3C);
        #1;
        assert_rst();
        #1;
        chk("midrst_q", Q, 8'h00);
        chk("midrst_qn", Q_N, 8'hFF);
        chk("midrst_zero", Zero, 1'b1);
        @(posedge Clk);
        #2;
        Rst = 1'b0;

        // 2: load then hold
        step(3'd3, 8'hA5, 0, 0, 0, 0);
        chk("load_q", Q, 8'hA5);
        chk("load_qn", Q_N, 8'h5A);
        chk("load_zero", Zero, 1'b0);
        for (int i = 0; i < 3; i++) step(3'd0, 8'h00, 1, 1, 0, 0);
        chk("hold_q", Q, 8'hA5);

        // 3: shift right with SerR=1
        chk("shr_sor0", SerOutR, 1'b1);
        step(3'd1, 8'h00, 1, 0, 0, 0);
        chk("shr_q1", Q, 8'hD2);
        chk("shr_sor1", SerOutR, 1'b0);
        step(3'd1, 8'h00, 1, 0, 0, 0);
        chk("shr_q2", Q, 8'hE9);

        // 4: rotate left, shift left, rotate right, reserved hold
        step(3'd3, 8'h81, 0, 0, 0, 0);
        step(3'd5, 8'h00, 0, 0, 0, 0);
        chk("rol_q1", Q, 8'h03);
        step(3'd5, 8'h00, 0, 0, 0, 0);
        chk("rol_q2", Q, 8'h06);
        step(3'd2, 8'h00, 0, 1, 0, 0);
        chk("shl_q", Q, 8'h0D);
        step(3'd4, 8'h00, 0, 0, 0, 0);
        chk("ror_q", Q, 8'h86);
        chk("ror_sol", SerOutL, 1'b1);
        step(3'd7, 8'h55, 1, 1, 0, 0);
        chk("rsvd_q", Q, 8'h86);
        step(3'd2, 8'h00, 1, 0, 0, 0);
        chk("shl0_q", Q, 8'h0C);

        // 5: priority Clr > Set > Mode, then invert
        step(3'd3, 8'hFF, 0, 0, 1, 1);
        chk("clrset_q", Q, 8'h00);
        step(3'd3, 8'h12, 0, 0, 0, 1);
        chk("set_q", Q, 8'hFF);
        chk("set_qn", Q_N, 8'h00);
        step(3'd6, 8'h00, 0, 0, 0, 0);
        chk("inv_q", Q, 8'h00);
        chk("inv_zero", Zero, 1'b1);
        step(3'd6, 8'h00, 0, 0, 0, 0);
        chk("inv2_q", Q, 8'hFF);

        // 6: reset during a shift sequence, roughly 2.5 cycles long
        step(3'd1, 8'h00, 1, 0, 0, 0);
        step(3'd1, 8'h00, 1, 0, 0, 0);
        #2;
        assert_rst();
        #1;
        chk("seqrst_q", Q, 8'h00);
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        step(3'd1, 8'h00, 1, 0, 0, 0);
        chk("post_rst_q", Q, 8'h80);

        @(negedge Clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
